// File: rtl/uart_tx_scheduler.sv
// Round-robin scheduler sharing one uart_tx between NUM_REQ byte producers.
// Optional: define UART_TX_SCHED_TAG_EN to precede each data frame with a {4'hA, grant_id} tag frame.
module uart_tx_scheduler #(
   parameter int unsigned NUM_REQ    = 4,
   parameter int unsigned GAP_CYCLES = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [NUM_REQ-1:0]   req,
   input  logic [8*NUM_REQ-1:0] req_data,
   output logic [NUM_REQ-1:0]   req_ack,
   output logic                 tx_start,
   output logic [7:0]           tx_byte,
   input  logic                 tx_done,
   input  logic                 tx_active,
   output logic                 busy,
   output logic [3:0]           grant_id
);

   localparam int unsigned PW = $clog2(NUM_REQ);
   localparam int unsigned CW = PW + 1;
   localparam int unsigned GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

`ifdef UART_TX_SCHED_TAG_EN
   typedef enum logic [2:0] {IDLE, START, WAIT_DONE, GAP, TAG_START, TAG_WAIT} state_e;
`else
   typedef enum logic [1:0] {IDLE, START, WAIT_DONE, GAP} state_e;
`endif

   state_e               state_q, state_d;
   logic [PW-1:0]        ptr_q, ptr_d;
   logic [GW-1:0]        gap_q, gap_d;
   logic [NUM_REQ-1:0]   req_ack_q, req_ack_d;
   logic                 tx_start_q, tx_start_d;
   logic [7:0]           tx_byte_q, tx_byte_d;
   logic [3:0]           grant_id_q, grant_id_d;
`ifdef UART_TX_SCHED_TAG_EN
   logic [7:0]           data_q, data_d;
`endif

   logic                 win_found;
   logic [PW-1:0]        win_idx;
   logic [PW-1:0]        win_next;
   logic [7:0]           win_byte;
   logic [CW-1:0]        cand;

   // Rotating search starting at the pointer; modulo done by a single conditional subtract.
   always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
      cand      = '0;
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
         cand = {1'b0, ptr_q} + CW'(k);
         if (cand >= CW'(NUM_REQ)) begin
            cand = cand - CW'(NUM_REQ);
         end
         if (!win_found && req[cand[PW-1:0]]) begin
            win_found = 1'b1;
            win_idx   = cand[PW-1:0];
         end
      end
   end

   always_comb begin
      win_byte = '0;
      for (int unsigned j = 0; j < NUM_REQ; j++) begin
         if (win_idx == PW'(j)) begin
            win_byte = req_data[8*j +: 8];
         end
      end
   end

   assign win_next = (win_idx == PW'(NUM_REQ - 1)) ? '0 : win_idx + PW'(1);

   always_comb begin
      state_d    = state_q;
      ptr_d      = ptr_q;
      gap_d      = gap_q;
      req_ack_d  = '0;
      tx_start_d = 1'b0;
      tx_byte_d  = tx_byte_q;
      grant_id_d = grant_id_q;
`ifdef UART_TX_SCHED_TAG_EN
      data_d     = data_q;
`endif
      unique case (state_q)
         IDLE: begin
            // tx_active gates the grant so a frame left running across a reset is never cut short.
            if (!tx_active && win_found) begin
               req_ack_d[win_idx] = 1'b1;
               tx_start_d         = 1'b1;
               grant_id_d         = 4'(win_idx);
               ptr_d              = win_next;
`ifdef UART_TX_SCHED_TAG_EN
               data_d             = win_byte;
               tx_byte_d          = {4'hA, 4'(win_idx)};
               state_d            = TAG_START;
`else
               tx_byte_d          = win_byte;
               state_d            = START;
`endif
            end
         end
`ifdef UART_TX_SCHED_TAG_EN
         TAG_START: state_d = TAG_WAIT;
         TAG_WAIT: begin
            if (tx_done) begin
               tx_byte_d  = data_q;
               tx_start_d = 1'b1;
               state_d    = START;
            end
         end
`endif
         START: state_d = WAIT_DONE;
         WAIT_DONE: begin
            if (tx_done) begin
               if (GAP_CYCLES == 0) begin
                  state_d = IDLE;
               end else begin
                  gap_d   = GW'(GAP_CYCLES - 1);
                  state_d = GAP;
               end
            end
         end
         GAP: begin
            if (gap_q == '0) begin
               state_d = IDLE;
            end else begin
               gap_d = gap_q - GW'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         ptr_q      <= '0;
         gap_q      <= '0;
         req_ack_q  <= '0;
         tx_start_q <= 1'b0;
         tx_byte_q  <= '0;
         grant_id_q <= '0;
`ifdef UART_TX_SCHED_TAG_EN
         data_q     <= '0;
`endif
      end else begin
         state_q    <= state_d;
         ptr_q      <= ptr_d;
         gap_q      <= gap_d;
         req_ack_q  <= req_ack_d;
         tx_start_q <= tx_start_d;
         tx_byte_q  <= tx_byte_d;
         grant_id_q <= grant_id_d;
`ifdef UART_TX_SCHED_TAG_EN
         data_q     <= data_d;
`endif
      end
   end

   assign req_ack  = req_ack_q;
   assign tx_start = tx_start_q;
   assign tx_byte  = tx_byte_q;
   assign grant_id = grant_id_q;
   assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Self-checking bench for uart_tx_scheduler: directed scenarios plus randomized traffic
// against a transaction-level round-robin model and a behavioural uart_tx responder.
`timescale 1ns/1ps
module tb_uart_tx_scheduler;

   localparam int NUM_REQ = 4;
   localparam int GAP     = 16;
   localparam int LIMIT   = 3000;
`ifdef UART_TX_SCHED_TAG_EN
   localparam bit TAG = 1'b1;
`else
   localparam bit TAG = 1'b0;
`endif

   logic                 clk = 1'b0;
   logic                 rst_n;
   logic [NUM_REQ-1:0]   req;
   logic [8*NUM_REQ-1:0] req_data;
   logic [NUM_REQ-1:0]   req_ack;
   logic                 tx_start;
   logic [7:0]           tx_byte;
   logic                 tx_done = 1'b0;
   logic                 tx_active;
   logic                 busy;
   logic [3:0]           grant_id;

   logic                 hold_active = 1'b0;
   bit                   u_busy = 1'b0;
   bit                   stab_en = 1'b1;
   int                   u_cnt = 0;
   logic [7:0]           u_byte = '0;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int last_done = -1000;
   int n_starts = 0;
   int n_acks = 0;

   logic [7:0] rq [NUM_REQ][$];
   int         next_at [NUM_REQ];
   int         mptr, w, total, grants, s, c, rc, n, a0, s0;
   logic [7:0] pend;

   uart_tx_scheduler #(.NUM_REQ(NUM_REQ), .GAP_CYCLES(GAP)) dut (
      .clk(clk), .rst_n(rst_n), .req(req), .req_data(req_data), .req_ack(req_ack),
      .tx_start(tx_start), .tx_byte(tx_byte), .tx_done(tx_done), .tx_active(tx_active),
      .busy(busy), .grant_id(grant_id)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   assign tx_active = u_busy | hold_active;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   // uart_tx stand-in: no reset, random frame length, tx_done and busy drop together.
   always @(negedge clk) begin
      if (tx_done) tx_done = 1'b0;
      if (u_busy) begin
         if (stab_en) chk("tx_byte_stable", tx_byte, u_byte);
         if (u_cnt == 0) begin
            u_busy    = 1'b0;
            tx_done   = 1'b1;
            last_done = cyc;
         end else begin
            u_cnt--;
         end
      end
      if (tx_start === 1'b1) begin
         n_starts++;
         u_busy = 1'b1;
         u_byte = tx_byte;
         u_cnt  = $urandom_range(2, 12);
      end
      if (req_ack !== '0) n_acks++;
   end

   function automatic logic [7:0] grant_byte(input int id, input logic [7:0] d);
      return TAG ? {4'hA, 4'(id)} : d;
   endfunction

   task automatic expect_grant(input int id, input logic [7:0] d, input bit drop,
                               input bit exact_gap, output int st);
      int k;
      k = 0;
      do begin @(negedge clk); k++; end while (req_ack === '0 && k < LIMIT);
      chk("grant_wait", 32'(k < LIMIT), 1);
      chk("ack", 32'(req_ack), 32'(1) << id);
      chk("start", 32'(tx_start), 1);
      chk("grant_id", 32'(grant_id), id);
      chk("busy", 32'(busy), 1);
      chk("first_byte", 32'(tx_byte), 32'(grant_byte(id, d)));
      st = cyc;
      if (exact_gap) chk("done_to_start", st - last_done, GAP + 2);
      if (drop) req[id] = 1'b0;
`ifdef UART_TX_SCHED_TAG_EN
      k = 0;
      do begin @(negedge clk); k++; end while (tx_start !== 1'b1 && k < LIMIT);
      chk("data_wait", 32'(k < LIMIT), 1);
      chk("data_byte", 32'(tx_byte), 32'(d));
      chk("data_no_ack", 32'(req_ack), 0);
      chk("tag_to_data", cyc - last_done, 1);
`endif
   endtask

   task automatic wait_quiet();
      int k;
      k = 0;
      while ((busy !== 1'b0 || u_busy || tx_done) && k < LIMIT) begin @(negedge clk); k++; end
      chk("quiet_wait", 32'(k < LIMIT), 1);
      @(negedge clk);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation exceeded its time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0; req = '0; req_data = '0;
      repeat (3) @(negedge clk);
      chk("rst_req_ack", 32'(req_ack), 0);
      chk("rst_tx_start", 32'(tx_start), 0);
      chk("rst_tx_byte", 32'(tx_byte), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_grant_id", 32'(grant_id), 0);
      rst_n = 1'b1;
      @(negedge clk);

      // All four held: 0,1,2,3,0,1 with exact gap between frames.
      for (int i = 0; i < NUM_REQ; i++) req_data[8*i +: 8] = 8'(8'h10 + i);
      req = '1;
      for (int g = 0; g < 6; g++) expect_grant(g % NUM_REQ, 8'(8'h10 + g % NUM_REQ), 1'b0, g > 0, s);
      req = '0;
      wait_quiet();

      // Pointer is 2: simultaneous req[1], req[3] -> 3 first, then 1.
      req_data[15:8] = 8'h21; req_data[31:24] = 8'h23;
      req[1] = 1'b1; req[3] = 1'b1;
      expect_grant(3, 8'h23, 1'b1, 1'b0, s);
      expect_grant(1, 8'h21, 1'b1, 1'b1, s);
      wait_quiet();

      // Single requester, latency and busy through the gap.
      a0 = n_acks; s0 = n_starts;
      req_data[23:16] = 8'h5C; req[2] = 1'b1; c = cyc;
      expect_grant(2, 8'h5C, 1'b1, 1'b0, s);
      chk("single_latency", s, c + 1);
`ifndef UART_TX_SCHED_TAG_EN
      @(negedge clk);
      chk("single_ack_pulse", 32'(req_ack), 0);
      chk("single_start_pulse", 32'(tx_start), 0);
      chk("single_byte_hold", 32'(tx_byte), 32'h5C);
`endif
      n = 0;
      while (busy !== 1'b0 && n < LIMIT) begin @(negedge clk); n++; end
      chk("single_busy_wait", 32'(n < LIMIT), 1);
      chk("single_busy_end", cyc - last_done, GAP + 1);
      chk("single_ack_count", n_acks - a0, 1);
      chk("single_start_count", n_starts - s0, TAG ? 2 : 1);
      wait_quiet();

      // tx_active held after reset blocks the grant.
      rst_n = 1'b0; hold_active = 1'b1; req = '0; req_data[7:0] = 8'h77;
      repeat (2) @(negedge clk);
      rst_n = 1'b1; req[0] = 1'b1;
      n = 0;
      repeat (50) begin @(negedge clk); if (tx_start === 1'b1) n++; end
      chk("active_blocks", n, 0);
      hold_active = 1'b0; c = cyc;
      expect_grant(0, 8'h77, 1'b1, 1'b0, s);
      chk("active_release", s, c + 1);
      wait_quiet();

      // Reset mid-frame: outputs clear, pointer back to 0, grant waits for uart_tx.
      req_data[23:16] = 8'h42; req[2] = 1'b1;
      expect_grant(2, 8'h42, 1'b1, 1'b0, s);
      @(negedge clk);
      stab_en = 1'b0; rst_n = 1'b0; rc = cyc;
      #1;
      chk("midrst_tx_start", 32'(tx_start), 0);
      chk("midrst_tx_byte", 32'(tx_byte), 0);
      chk("midrst_req_ack", 32'(req_ack), 0);
      chk("midrst_busy", 32'(busy), 0);
      chk("midrst_grant_id", 32'(grant_id), 0);
      @(negedge clk);
      rst_n = 1'b1;
      req_data[15:8] = 8'h51; req_data[31:24] = 8'h53;
      req[1] = 1'b1; req[3] = 1'b1;
      expect_grant(1, 8'h51, 1'b1, 1'b0, s);
      chk("midrst_waits_uart", 32'((last_done > rc) && (s > last_done)), 1);
      stab_en = 1'b1;
      expect_grant(3, 8'h53, 1'b1, 1'b1, s);
      wait_quiet();

`ifdef UART_TX_SCHED_TAG_EN
      a0 = n_acks; s0 = n_starts;
      req_data[15:8] = 8'h33; req[1] = 1'b1;
      expect_grant(1, 8'h33, 1'b1, 1'b0, s);
      wait_quiet();
      chk("tag_ack_count", n_acks - a0, 1);
      chk("tag_start_count", n_starts - s0, 2);
`endif

      // Randomized traffic against a round-robin order model.
      rst_n = 1'b0; req = '0;
      @(negedge clk);
      rst_n = 1'b1;
      mptr = 0; total = 0; grants = 0; pend = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         rq[i].delete();
         for (int b = 0; b < 6; b++) rq[i].push_back(8'($urandom));
         next_at[i] = cyc + int'($urandom_range(0, 30));
         total += 6;
      end
      n = 0;
      while (grants < total && n < 20000) begin
         @(negedge clk); n++;
         if (req_ack !== '0) begin
            w = -1;
            for (int k = 0; k < NUM_REQ; k++)
               if (w < 0 && req[(mptr + k) % NUM_REQ]) w = (mptr + k) % NUM_REQ;
            if (w < 0) begin
               chk("rnd_unrequested_ack", 32'(req_ack), 0);
               grants++;
            end else begin
               chk("rnd_ack", 32'(req_ack), 32'(1) << w);
               chk("rnd_grant_id", 32'(grant_id), w);
               chk("rnd_start", 32'(tx_start), 1);
               chk("rnd_byte", 32'(tx_byte), 32'(grant_byte(w, rq[w][0])));
               chk("rnd_spacing", 32'(cyc - last_done >= GAP + 2), 1);
               pend = rq[w].pop_front();
               mptr = (w + 1) % NUM_REQ;
               grants++;
               req[w] = 1'b0;
               next_at[w] = cyc + int'($urandom_range(0, 4));
            end
         end else if (tx_start === 1'b1) begin
`ifdef UART_TX_SCHED_TAG_EN
            chk("rnd_data_byte", 32'(tx_byte), 32'(pend));
`else
            chk("rnd_stray_start", 32'(tx_start), 0);
`endif
         end
         for (int i = 0; i < NUM_REQ; i++) begin
            if (!req[i] && rq[i].size() > 0 && cyc >= next_at[i]) begin
               req[i] = 1'b1;
               req_data[8*i +: 8] = rq[i][0];
            end
         end
      end
      chk("rnd_all_served", grants, total);
      wait_quiet();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
